// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: decodes frames into a held-key map for ten game keys.
// Optional odd-parity rejection is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic       controller_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [9:0] o_keyboard_status,
    output logic [7:0] o_scan_code,
    output logic       o_code_valid,
    output logic       o_frame_error
);

    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state_q, state_d;
    logic            clk_meta_q, clk_sync_q, clk_prev_q;
    logic            dat_meta_q, dat_sync_q;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic [9:0]      status_q, status_d;
    logic [7:0]      scan_q, scan_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            brk_q, brk_d;
    logic            ext_q, ext_d;
    logic            fall_edge;
    logic            timeout;
    logic [9:0]      key_mask;
`ifdef PS2_PARITY_CHECK_EN
    logic            parity_q, parity_d;
`endif

    always_ff @(posedge controller_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= i_ps2_clk;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= i_ps2_data;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign fall_edge = clk_prev_q & ~clk_sync_q;
    // An edge arriving on the expiry cycle keeps the frame alive.
    assign timeout   = (state_q != IDLE) && !fall_edge && (wd_q == WDW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        case (shift_q)
            8'h1D:   key_mask = 10'h001;
            8'h1B:   key_mask = 10'h002;
            8'h1C:   key_mask = 10'h004;
            8'h23:   key_mask = 10'h008;
            8'h43:   key_mask = 10'h010;
            8'h42:   key_mask = 10'h020;
            8'h3B:   key_mask = 10'h040;
            8'h4B:   key_mask = 10'h080;
            8'h29:   key_mask = 10'h100;
            8'h5A:   key_mask = 10'h200;
            default: key_mask = 10'h000;
        endcase
    end

    always_ff @(posedge controller_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = IDLE;
        end else if (fall_edge) begin
            case (state_q)
                IDLE:    if (!dat_sync_q) state_d = DATA;
                DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        status_d  = status_q;
        scan_d    = scan_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        brk_d     = brk_q;
        ext_d     = ext_q;
`ifdef PS2_PARITY_CHECK_EN
        parity_d  = parity_q;
`endif
        wd_d = (state_q == IDLE || fall_edge) ? '0 : wd_q + WDW'(1);
        if (timeout) begin
            err_d = 1'b1;
            brk_d = 1'b0;
            ext_d = 1'b0;
        end else if (fall_edge) begin
            case (state_q)
                IDLE: bit_cnt_d = 3'd0;
                DATA: begin
                    shift_d   = {dat_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_d = dat_sync_q;
`endif
                end
                default: begin
                    if (!dat_sync_q) begin
                        err_d = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                    end else if (!(^{shift_q, parity_q})) begin
                        err_d = 1'b1;
`endif
                    end else begin
                        valid_d = 1'b1;
                        scan_d  = shift_q;
                        if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else begin
                            if (!ext_q)
                                status_d = brk_q ? (status_q & ~key_mask) : (status_q | key_mask);
                            brk_d = 1'b0;
                            ext_d = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge controller_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            wd_q      <= '0;
            status_q  <= '0;
            scan_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            wd_q      <= wd_d;
            status_q  <= status_d;
            scan_q    <= scan_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            brk_q     <= brk_d;
            ext_q     <= ext_d;
`ifdef PS2_PARITY_CHECK_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign o_keyboard_status = status_q;
    assign o_scan_code       = scan_q;
    assign o_code_valid      = valid_q;
    assign o_frame_error     = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder with a scoreboard of expected output events.
module tb_ps2_key_decoder;

    localparam int TMO = 200;

    logic       controller_clk = 1'b0;
    logic       i_rst_n;
    logic       i_ps2_clk;
    logic       i_ps2_data;
    logic [9:0] o_keyboard_status;
    logic [7:0] o_scan_code;
    logic       o_code_valid;
    logic       o_frame_error;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .controller_clk    (controller_clk),
        .i_rst_n           (i_rst_n),
        .i_ps2_clk         (i_ps2_clk),
        .i_ps2_data        (i_ps2_data),
        .o_keyboard_status (o_keyboard_status),
        .o_scan_code       (o_scan_code),
        .o_code_valid      (o_code_valid),
        .o_frame_error     (o_frame_error)
    );

    always #5 controller_clk = ~controller_clk;

    typedef struct {
        bit         err;
        logic [7:0] scan;
        logic [9:0] status;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         fails = 0;
    logic [9:0] m_status = '0;
    bit         m_brk = 0;
    bit         m_ext = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [9:0] key_bit(input logic [7:0] c);
        case (c)
            8'h1D: return 10'd1 << 0;
            8'h1B: return 10'd1 << 1;
            8'h1C: return 10'd1 << 2;
            8'h23: return 10'd1 << 3;
            8'h43: return 10'd1 << 4;
            8'h42: return 10'd1 << 5;
            8'h3B: return 10'd1 << 6;
            8'h4B: return 10'd1 << 7;
            8'h29: return 10'd1 << 8;
            8'h5A: return 10'd1 << 9;
            default: return 10'd0;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b);
        exp_t e;
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else begin
            if (!m_ext) begin
                if (m_brk) m_status = m_status & ~key_bit(b);
                else       m_status = m_status | key_bit(b);
            end
            m_brk = 0;
            m_ext = 0;
        end
        e.err = 0; e.scan = b; e.status = m_status;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.err = 1; e.scan = 8'h00; e.status = m_status;
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input bit v);
        i_ps2_data = v;
        #100 i_ps2_clk = 1'b0;
        #200 i_ps2_clk = 1'b1;
        #100;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = (~^b) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(~bad_stop);
        i_ps2_data = 1'b1;
        #500;
    endtask

    task automatic good_frame(input logic [7:0] b);
        model_byte(b);
        send_frame(b, 1'b0, 1'b0);
    endtask

    always @(negedge controller_clk) begin
        if (i_rst_n && (o_code_valid || o_frame_error)) begin
            exp_t e;
            check("valid_err_exclusive", {31'd0, o_code_valid & o_frame_error}, 0);
            check("event_expected", {31'd0, exp_q.size() > 0}, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("event_kind_err", {31'd0, o_frame_error}, {31'd0, e.err});
                if (!e.err) check("scan_code", {24'd0, o_scan_code}, {24'd0, e.scan});
                check("status_at_event", {22'd0, o_keyboard_status}, {22'd0, e.status});
            end
        end
    end

    initial begin
        i_rst_n    = 1'b0;
        i_ps2_clk  = 1'b1;
        i_ps2_data = 1'b1;
        repeat (5) @(posedge controller_clk);
        @(negedge controller_clk);
        check("rst_status", {22'd0, o_keyboard_status}, 0);
        check("rst_scan", {24'd0, o_scan_code}, 0);
        check("rst_valid", {31'd0, o_code_valid}, 0);
        check("rst_err", {31'd0, o_frame_error}, 0);
        i_rst_n = 1'b1;
        #300;

        good_frame(8'h1D);
        check("w_held", {22'd0, o_keyboard_status}, 32'h001);
        good_frame(8'h29);
        good_frame(8'hF0);
        good_frame(8'h1D);
        check("space_only", {22'd0, o_keyboard_status}, 32'h100);
        good_frame(8'hF0);
        good_frame(8'h29);
        good_frame(8'hE0);
        good_frame(8'h5A);
        check("ext_ignored", {22'd0, o_keyboard_status}, 32'h000);
        good_frame(8'h5A);
        check("enter_held", {22'd0, o_keyboard_status}, 32'h200);
        good_frame(8'hF0);
        good_frame(8'h5A);

        push_err();
        send_frame(8'h23, 1'b0, 1'b1);
        check("stop_err_status", {22'd0, o_keyboard_status}, 32'h000);

        // Partial frame then silence: watchdog must abandon it.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        m_brk = 0; m_ext = 0;
        push_err();
        repeat (TMO + 40) @(posedge controller_clk);
        good_frame(8'h1C);
        check("a_after_timeout", {22'd0, o_keyboard_status}, 32'h004);
        good_frame(8'h1C);
        good_frame(8'h55);
        good_frame(8'hE0);
        good_frame(8'hF0);
        good_frame(8'h1C);
        check("a_still_held", {22'd0, o_keyboard_status}, 32'h004);

        // Start bit of 1 is not a frame and produces nothing.
        send_bit(1'b1);
        #500;

`ifdef PS2_PARITY_CHECK_EN
        push_err();
`else
        model_byte(8'h43);
`endif
        send_frame(8'h43, 1'b1, 1'b0);
        check("parity_case", {22'd0, o_keyboard_status}, {22'd0, m_status});

        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        i_rst_n = 1'b0;
        m_status = '0; m_brk = 0; m_ext = 0;
        repeat (3) @(posedge controller_clk);
        @(negedge controller_clk);
        check("midreset_status", {22'd0, o_keyboard_status}, 0);
        check("midreset_scan", {24'd0, o_scan_code}, 0);
        i_rst_n = 1'b1;
        #300;
        good_frame(8'h5A);
        check("after_reset", {22'd0, o_keyboard_status}, 32'h200);
        good_frame(8'h1B);
        check("s_and_enter", {22'd0, o_keyboard_status}, 32'h202);

        #1000;
        check("all_events_seen", exp_q.size(), 0);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
